// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM driver: default widths and
// small elaboration-time helpers used by the top and its prescaler.
package pwm_pkg;

  localparam int PWM_CNT_W_DEFAULT = 13;

  // Saturate a requested duty to the full-on value of a frame.
  function automatic int unsigned duty_clamp(input int unsigned duty,
                                             input int unsigned limit);
    return (duty > limit) ? limit : duty;
  endfunction

  function automatic int ch_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides i_clk into a one-cycle tick strobe every PRESCALE cycles; the
// count is held at zero while disabled so a re-enable restarts a full period.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 1000,
  localparam int PW = $clog2(PRESCALE)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_tick
);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign o_tick = i_enable && (presc == PRESC_LAST);

endmodule

// File: rtl/pwm_multi_driver.sv
// Multi-channel PWM generator: one prescaler and frame counter shared by
// CHANNELS comparators with double-buffered duties committed at frame end.
module pwm_multi_driver
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = PWM_CNT_W_DEFAULT,
  parameter int PRESCALE = 1000,
  parameter int PERIOD   = 2000,
  parameter int DUTY_RST = 50,
  parameter bit INVERT   = 1'b0,
  localparam int CH_W    = ch_idx_w(CHANNELS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [CH_W-1:0]     i_wr_ch,
  input  logic [CNT_W-1:0]    i_wr_duty,
  output logic [CHANNELS-1:0] o_signal,
  output logic                o_frame_start
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] DUTY_INIT = CNT_W'(duty_clamp(DUTY_RST, PERIOD + 1));

  logic                tick;
  logic                commit;
  logic                wr_accept;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    wr_duty_sat;
  logic [CHANNELS-1:0] cmp;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (i_enable),
    .o_tick   (tick)
  );

  // Ready drops only in the commit cycle, so a shadow write never lands in
  // the same edge that copies shadows into the active registers.
  assign commit      = tick && (cnt == CNT_LAST);
  assign o_wr_ready  = !commit && !i_rst;
  assign wr_accept   = i_wr_valid && o_wr_ready;
  assign wr_duty_sat = CNT_W'(duty_clamp(32'(i_wr_duty), PERIOD + 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= commit;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [CNT_W-1:0] duty_shd;
    logic [CNT_W-1:0] duty_act;
    logic             ch_hit;

    // Out-of-range channel indices match no k and are silently dropped.
    assign ch_hit = wr_accept && (i_wr_ch == CH_W'(k));

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        duty_shd <= DUTY_INIT;
      end else if (ch_hit) begin
        duty_shd <= wr_duty_sat;
      end
    end

    // While stopped the active copy tracks the shadow, so a restart begins
    // with the most recently written duty.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        duty_act <= DUTY_INIT;
      end else if (!i_enable || commit) begin
        duty_act <= duty_shd;
      end
    end

    assign cmp[k] = (cnt < duty_act);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      o_signal <= {CHANNELS{INVERT}};
    end else begin
      o_signal <= cmp ^ {CHANNELS{INVERT}};
    end
  end

endmodule

// File: tb/tb_pwm_multi_driver.sv
// Directed bench for pwm_multi_driver: per-frame high-time vectors plus
// hand-written disable, re-enable and mid-frame reset sequences.
module tb_pwm_multi_driver;

  localparam int CHANNELS = 3;
  localparam int CNT_W    = 5;
  localparam int PRESCALE = 4;
  localparam int PERIOD   = 9;
  localparam int DUTY_RST = 3;
  localparam int FRAME    = PRESCALE * (PERIOD + 1);

  logic                clk;
  logic                rst;
  logic                enable;
  logic                wr_valid;
  logic                wr_ready;
  logic [1:0]          wr_ch;
  logic [CNT_W-1:0]    wr_duty;
  logic [CHANNELS-1:0] sig;
  logic                frame_start;

  int tests_run;
  int tests_failed;

  // Write held across windows until accepted.
  bit               pend;
  logic [1:0]       pend_ch;
  logic [CNT_W-1:0] pend_duty;
  int               hi [CHANNELS];

  typedef struct {
    int               wr_at;
    logic [1:0]       ch;
    logic [CNT_W-1:0] duty;
    logic             exp_rdy;
    int               exp0;
    int               exp1;
    int               exp2;
  } vec_t;

  vec_t vecs [12];

  pwm_multi_driver #(
    .CHANNELS (CHANNELS),
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE),
    .PERIOD   (PERIOD),
    .DUTY_RST (DUTY_RST),
    .INVERT   (1'b0)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_wr_valid    (wr_valid),
    .o_wr_ready    (wr_ready),
    .i_wr_ch       (wr_ch),
    .i_wr_duty     (wr_duty),
    .o_signal      (sig),
    .o_frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts at the negedge of a frame's first cycle (C0); counts outputs over
  // C1..C40 and ends in the next frame's first cycle. A write requested at
  // step wr_at is driven during C(wr_at-1) and held until accepted.
  task automatic run_window(input string tag, input int wr_at, input logic [1:0] ch,
                            input logic [CNT_W-1:0] duty, input logic exp_rdy);
    bit seen_low [CHANNELS];
    int shape_bad;
    int fs_early;
    bit acc;
    shape_bad = 0;
    fs_early  = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      hi[c]       = 0;
      seen_low[c] = 1'b0;
    end
    for (int i = 1; i <= FRAME; i++) begin
      if (wr_at != 0 && i == wr_at) begin
        pend      = 1'b1;
        pend_ch   = ch;
        pend_duty = duty;
        check({tag, " ready_at_request"}, 32'(wr_ready), 32'(exp_rdy));
      end
      wr_valid = pend;
      wr_ch    = pend_ch;
      wr_duty  = pend_duty;
      acc      = pend && wr_ready;
      @(negedge clk);
      if (acc) pend = 1'b0;
      wr_valid = pend;
      for (int c = 0; c < CHANNELS; c++) begin
        if (sig[c]) begin
          hi[c]++;
          if (seen_low[c]) shape_bad++;
        end else begin
          seen_low[c] = 1'b1;
        end
      end
      if (i < FRAME && frame_start) fs_early++;
    end
    check({tag, " frame_start_at_end"}, 32'(frame_start), 1);
    check({tag, " frame_start_early"}, fs_early, 0);
    check({tag, " pulse_not_contiguous"}, shape_bad, 0);
  endtask

  initial begin
    int n_bad;
    tests_run    = 0;
    tests_failed = 0;
    pend         = 1'b0;
    pend_ch      = '0;
    pend_duty    = '0;
    rst          = 1'b1;
    enable       = 1'b0;
    wr_valid     = 1'b0;
    wr_ch        = '0;
    wr_duty      = '0;

    //           wr_at ch  duty   rdy   ch0 ch1 ch2
    vecs[0]  = '{0,  2'd0, 5'd0,  1'b1, 12, 12, 12};
    vecs[1]  = '{18, 2'd1, 5'd7,  1'b1, 12, 12, 12};
    vecs[2]  = '{0,  2'd0, 5'd0,  1'b1, 12, 28, 12};
    vecs[3]  = '{5,  2'd0, 5'd0,  1'b1, 12, 28, 12};
    vecs[4]  = '{30, 2'd2, 5'd20, 1'b1, 0,  28, 12};
    vecs[5]  = '{0,  2'd0, 5'd0,  1'b1, 0,  28, 40};
    vecs[6]  = '{10, 2'd3, 5'd9,  1'b1, 0,  28, 40};
    vecs[7]  = '{0,  2'd0, 5'd0,  1'b1, 0,  28, 40};
    vecs[8]  = '{0,  2'd0, 5'd0,  1'b1, 0,  28, 40};
    vecs[9]  = '{40, 2'd1, 5'd2,  1'b0, 0,  28, 40};
    vecs[10] = '{0,  2'd0, 5'd0,  1'b1, 0,  28, 40};
    vecs[11] = '{0,  2'd0, 5'd0,  1'b1, 0,  8,  40};

    // Reset for two cycles.
    @(negedge clk);
    check("reset signal", 32'(sig), 0);
    check("reset ready", 32'(wr_ready), 0);
    check("reset frame_start", 32'(frame_start), 0);
    @(negedge clk);
    check("reset signal 2nd cycle", 32'(sig), 0);
    rst    = 1'b0;
    enable = 1'b1;
    #1;
    check("ready after reset", 32'(wr_ready), 1);

    // Frame-by-frame vectors; a write in window n shows in window n+1.
    for (int v = 0; v < 12; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_window(tag, vecs[v].wr_at, vecs[v].ch, vecs[v].duty, vecs[v].exp_rdy);
      check({tag, " ch0_high"}, hi[0], vecs[v].exp0);
      check({tag, " ch1_high"}, hi[1], vecs[v].exp1);
      check({tag, " ch2_high"}, hi[2], vecs[v].exp2);
    end
    check("ch2 shadow clamped", 32'(dut.g_ch[2].duty_shd), 10);

    // Disable at cnt=5 (cycles 20..23 of the frame); duties are {0,2,10}.
    repeat (21) @(negedge clk);
    check("pre-disable signal", 32'(sig), 32'(3'b100));
    enable = 1'b0;
    @(negedge clk);
    check("disable signal", 32'(sig), 0);
    check("disable ready", 32'(wr_ready), 1);
    wr_valid = 1'b1;
    wr_ch    = 2'd0;
    wr_duty  = 5'd5;
    @(negedge clk);
    wr_valid = 1'b0;
    n_bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (sig != '0 || frame_start) n_bad++;
      @(negedge clk);
    end
    check("disabled outputs idle", n_bad, 0);

    // Restart: counting from presc=0/cnt=0, full 40-cycle first frame.
    enable = 1'b1;
    run_window("restart", 0, 2'd0, 5'd0, 1'b1);
    check("restart ch0_high", hi[0], 20);
    check("restart ch1_high", hi[1], 8);
    check("restart ch2_high", hi[2], 40);

    // Mid-frame reset discards an uncommitted shadow write.
    repeat (5) @(negedge clk);
    check("ready before lost write", 32'(wr_ready), 1);
    wr_valid = 1'b1;
    wr_ch    = 2'd1;
    wr_duty  = 5'd9;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid-frame reset ready", 32'(wr_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    check("post-reset signal", 32'(sig), 0);
    check("post-reset frame_start", 32'(frame_start), 0);
    run_window("after_reset", 0, 2'd0, 5'd0, 1'b1);
    check("after_reset ch0_high", hi[0], 12);
    check("after_reset ch1_high", hi[1], 12);
    check("after_reset ch2_high", hi[2], 12);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
